// File: rtl/sprite_cmd_encoder.sv
`default_nettype none
// ============================================================================
// Module  : sprite_cmd_encoder
// Purpose : Buffers sprite records and serializes them onto the 32-bit sprite
//           command bus, inserting ping/pong flush words at frame boundaries.
// Revision: 1.0 - initial release
// ============================================================================
module sprite_cmd_encoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int PTR_W      = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_sub_comp,
  input  logic [4:0]       req_child_comp,
  input  logic             req_visible,
  input  logic             req_flip,
  input  logic [4:0]       req_pattern,
  input  logic [9:0]       req_x,
  input  logic [9:0]       req_y,
  input  logic [9:0]       req_shift,
  input  logic             frame_end,
  output logic [31:0]      writedata,
  output logic             back_buf,
  output logic [PTR_W:0]   fifo_level,
  output logic             busy
);

  typedef struct packed {
    logic [5:0] sub_comp;
    logic [4:0] child_comp;
    logic       visible;
    logic       flip;
    logic [4:0] pattern;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] shift;
  } rec_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ATTR  = 3'd1,
    S_XC    = 3'd2,
    S_YC    = 3'd3,
    S_SHF   = 3'd4,
    S_FLUSH = 3'd5
  } state_t;

  localparam logic [PTR_W:0] c_full_lvl = FIFO_DEPTH[PTR_W:0];
  localparam logic [31:0]    c_nop      = 32'h0;

  rec_t             r_mem [FIFO_DEPTH];
  rec_t             r_cur;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  state_t           r_state;
  logic             r_flush_pending;
  logic             r_back_buf;
  logic [31:0]      r_writedata;

  state_t           w_state_nxt;
  logic [31:0]      w_word_nxt;
  logic             w_pop;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  logic             w_pend_eff;
  logic             w_bb_next;
  rec_t             w_head;
  rec_t             w_req;

  function automatic logic [31:0] rec_word(input logic [5:0]  sub,
                                           input logic [4:0]  child,
                                           input logic [2:0]  typ,
                                           input logic        pp,
                                           input logic [12:0] msg);
    return {sub, child, 4'b0001, typ, pp, msg};
  endfunction

  assign w_req = '{sub_comp: req_sub_comp, child_comp: req_child_comp,
                   visible: req_visible, flip: req_flip, pattern: req_pattern,
                   x: req_x, y: req_y, shift: req_shift};

  assign w_full    = (r_count == c_full_lvl);
  assign w_empty   = (r_count == '0);
  assign w_push    = req_valid && !w_full;
  assign w_head    = r_mem[r_rd_ptr];
  // The flush being serviced in FLUSH is already consumed; only a fresh
  // frame_end (registered next edge) can re-arm it.
  assign w_pend_eff = r_flush_pending && (r_state != S_FLUSH);
  assign w_bb_next  = (r_state == S_FLUSH) ? ~r_back_buf : r_back_buf;

  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = c_nop;
    w_pop       = 1'b0;
    case (r_state)
      S_ATTR: begin
        w_state_nxt = S_XC;
        w_word_nxt  = rec_word(r_cur.sub_comp, r_cur.child_comp, 3'b010,
                               r_back_buf, {3'b000, r_cur.x});
      end
      S_XC: begin
        w_state_nxt = S_YC;
        w_word_nxt  = rec_word(r_cur.sub_comp, r_cur.child_comp, 3'b011,
                               r_back_buf, {3'b000, r_cur.y});
      end
      S_YC: begin
        w_state_nxt = S_SHF;
        w_word_nxt  = rec_word(r_cur.sub_comp, r_cur.child_comp, 3'b100,
                               r_back_buf, {3'b000, r_cur.shift});
      end
      default: begin
        // Record-boundary decision: pending flush beats queued records.
        if (w_pend_eff) begin
          w_state_nxt = S_FLUSH;
          w_word_nxt  = {6'd0, 5'd0, 4'b1111, 3'b000, w_bb_next, 13'd0};
        end else if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_ATTR;
          w_word_nxt  = rec_word(w_head.sub_comp, w_head.child_comp, 3'b001,
                                 w_bb_next,
                                 {w_head.visible, w_head.flip, 6'd0, w_head.pattern});
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_req;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_writedata     <= c_nop;
      r_back_buf      <= 1'b1;
      r_flush_pending <= 1'b0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_cur           <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_writedata     <= w_word_nxt;
      r_back_buf      <= w_bb_next;
      r_flush_pending <= frame_end | w_pend_eff;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_cur    <= w_head;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign req_ready  = !w_full;
  assign writedata  = r_writedata;
  assign back_buf   = r_back_buf;
  assign fifo_level = r_count;
  assign busy       = (r_state != S_IDLE) || !w_empty || r_flush_pending;

endmodule
`default_nettype wire

// File: doc/sprite_cmd_encoder.md
Name: sprite_cmd_encoder

Overview:
- Producer end of the 32-bit sprite command bus that feeds every sprite display sub-component (for example, Mario with sub_comp 1).
- Accepts whole sprite attribute records through a valid/ready handshake and buffers them in a FIFO.
- Serializes each record into four command words: attribute, x, y, shift. All words target the current back buffer.
- On each frame boundary, inserts a flush word that swaps the ping/pong buffers.

Parameters:
- FIFO_DEPTH, 8, record FIFO entries (power of 2, minimum 2).
- PTR_W, 3, log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  record offered.
- req_ready  out  1  FIFO can accept a record.
- req_sub_comp  in  6  target sub-component ID.
- req_child_comp  in  5  target child ID.
- req_visible  in  1  visible flag.
- req_flip  in  1  flip flag.
- req_pattern  in  5  pattern code.
- req_x  in  10  x coordinate.
- req_y  in  10  y coordinate.
- req_shift  in  10  shift amount.
- frame_end  in  1  one-cycle pulse at frame boundary.
- writedata  out  32  registered command word to the display modules.
- back_buf  out  1  buffer currently being written (pp_selc of record words).
- fifo_level  out  PTR_W+1  FIFO occupancy.
- busy  out  1  FSM not in IDLE, or FIFO non-empty, or flush pending.

Behaviour:
- Word layout: {sub_comp[31:26], child_comp[25:21], info[20:17], type[16:14], pp_selc[13], msg[12:0]}.
- NOP word: 32'h0.
- Attribute word: info=4'b0001, type=3'b001, msg={visible, flip, 6'b0, pattern}.
- X word: info=4'b0001, type=3'b010, msg={3'b0, x}.
- Y word: info=4'b0001, type=3'b011, msg={3'b0, y}.
- Shift word: info=4'b0001, type=3'b100, msg={3'b0, shift}.
- Record words carry pp_selc=back_buf.
- Flush word: sub_comp=0, child_comp=0, info=4'b1111, type=0, pp_selc=back_buf, msg=0.
- Reset (async, asserted low):
  - writedata=0, back_buf=1 (display shows buffer 0 after reset).
  - FIFO empty, fifo_level=0, req_ready=1, state IDLE, flush_pending=0, busy=0.
- Push: a record is accepted on the rising edge where req_valid && req_ready. req_ready = !full, combinational from occupancy.
- States: IDLE, ATTR, XC, YC, SHF, FLUSH. writedata is registered and loaded on the same edge the state is entered, with that state's word. IDLE loads NOP.
- Record words are built from the cur register, which is loaded at pop.
- Transition rule R, applied from IDLE and from SHF:
  - If flush_pending: go to FLUSH.
  - Else if FIFO non-empty: pop into cur and go to ATTR.
  - Else: go to IDLE.
- Fixed sequence: ATTR -> XC -> YC -> SHF. FLUSH -> rule R.
- Timing and throughput:
  - A record accepted at edge N, with the FSM idle, drives ATTR after edge N+1, then XC, YC, SHF on the following three edges.
  - Back-to-back records sustain 4 cycles per record with no NOP between them.
- Flush:
  - Only ever inserted at a record boundary; a record is never split.
  - On the edge leaving FLUSH, back_buf toggles.
  - flush_pending_next = frame_end | (flush_pending & state!=FLUSH).
  - Multiple frame_end pulses before a flush coalesce into a single flush.
  - A frame_end pulse on the FLUSH cycle itself sets a new pending flush.
- Flush priority: a pending flush wins over a non-empty FIFO. Records still queued are written into the new back buffer.
- Simultaneous push and pop: both occur and fifo_level is unchanged. When full, req_ready=0, so only the pop occurs.
- Pointers: wrap modulo FIFO_DEPTH. Occupancy saturates at FIFO_DEPTH, because full blocks push.
- Reset mid-operation:
  - Immediate return to reset values; any partially emitted record is abandoned.
  - writedata=0 the same instant, so no spurious word is seen.
- Field widths pass through unmodified; no range check is made on pattern (the display ignores codes at or above its pattern_num).

Test Plan:
1. Reset, then idle for 10 cycles -> writedata=0, back_buf=1, req_ready=1, fifo_level=0, busy=0.
2. Push one record: sub=1, child=0, vis=1, flip=0, pat=7, x=100, y=200, shift=0 -> writedata sequence 0x04027007, 0x0402A064, 0x0402E0C8, 0x04032000 on consecutive cycles, then 0.
3. Push 9 records back-to-back with the FSM held busy (FIFO_DEPTH=8) -> req_ready deasserts when fifo_level=8, and the 9th record is accepted only after a pop. Output shows 36 contiguous record words with no NOP and records in push order.
4. Pulse frame_end while record 1 is in XC, with record 2 queued:
   - Record 1 completes, then 0x001E2000 (flush, pp=1), then back_buf=0.
   - Record 2's attribute word then has bit13=0.
5. Two frame_end pulses 3 cycles apart while busy -> exactly one flush word is emitted. A third pulse on the FLUSH cycle produces a second flush, 0x001E0000, after the next record boundary.
6. Assert reset low during YC of a record -> writedata=0 asynchronously, FIFO empty, back_buf=1. After release with no pushes, only NOPs are emitted.
